// File: rtl/inert_serf_pkg.sv
// ============================================================================
// Module   : inert_serf_pkg
// Brief    : Shared register map, INT enable bit and FSM encoding for inert_spi_serf.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inert_serf_pkg;

    localparam logic [6:0] INT_CTRL_ADDR = 7'h0D;
    localparam logic [6:0] CFG_10_ADDR   = 7'h10;
    localparam logic [6:0] CFG_11_ADDR   = 7'h11;
    localparam logic [6:0] CFG_14_ADDR   = 7'h14;
    localparam logic [6:0] ROLL_L_ADDR   = 7'h24;
    localparam logic [6:0] ROLL_H_ADDR   = 7'h25;
    localparam logic [6:0] YAW_L_ADDR    = 7'h26;
    localparam logic [6:0] YAW_H_ADDR    = 7'h27;
    localparam logic [6:0] AY_L_ADDR     = 7'h2A;
    localparam logic [6:0] AY_H_ADDR     = 7'h2B;
    localparam logic [6:0] AZ_L_ADDR     = 7'h2C;
    localparam logic [6:0] AZ_H_ADDR     = 7'h2D;

    localparam int         INT_EN_BIT    = 1;
    localparam logic [4:0] BIT_CNT_SAT   = 5'd17;
    localparam logic [4:0] BIT_CNT_FRAME = 5'd16;
    localparam logic [4:0] BIT_CNT_BYTE  = 5'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } serf_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_serf_sync.sv
// ============================================================================
// Module   : spi_serf_sync
// Brief    : Double-flop synchronizer plus edge detect for the SPI pins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_serf_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic ss_fall,
    output logic ss_rise,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s
);

    // [0] and [1] are the metastability pair, [2] is the edge-detect history.
    logic [2:0] r_ss;
    logic [2:0] r_sclk;
    logic [1:0] r_mosi;

    // Select and clock reset to their idle-high level so reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss   <= 3'b111;
            r_sclk <= 3'b111;
            r_mosi <= 2'b00;
        end else begin
            r_ss   <= {r_ss[1:0], SS_n};
            r_sclk <= {r_sclk[1:0], SCLK};
            r_mosi <= {r_mosi[0], MOSI};
        end
    end

    assign ss_fall   =  r_ss[2]   & ~r_ss[1];
    assign ss_rise   = ~r_ss[2]   &  r_ss[1];
    assign sclk_rise = ~r_sclk[2] &  r_sclk[1];
    assign sclk_fall =  r_sclk[2] & ~r_sclk[1];
    assign mosi_s    =  r_mosi[1];

endmodule

`default_nettype wire

// File: rtl/inert_spi_serf.sv
// ============================================================================
// Module   : inert_spi_serf
// Brief    : SPI responder modelling the eBike inertial sensor (regs, shadow words, INT).
//            Define INERT_SERF_PERIODIC_EN to self-generate updates every ODR_CYC clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inert_spi_serf
    import inert_serf_pkg::*;
#(
    parameter logic [15:0] ODR_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        upd,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] AY,
    input  logic [15:0] AZ,
    output logic        MISO,
    output logic        INT
);

    serf_state_t r_state;
    serf_state_t w_state_nxt;

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_mosi_s;

    logic [4:0]  r_bit_cnt;
    logic [15:0] r_rx;
    logic [15:0] r_tx;
    logic [15:0] w_rx_nxt;
    logic [7:0]  w_rd_byte;
    logic        w_load_rd;

    logic [7:0]  r_int_ctrl;
    logic [7:0]  r_cfg10;
    logic [7:0]  r_cfg11;
    logic [7:0]  r_cfg14;
    logic [15:0] r_roll;
    logic [15:0] r_yaw;
    logic [15:0] r_ay;
    logic [15:0] r_az;
    logic        r_int;

    logic        w_upd;
    logic        w_commit_ok;
    logic        w_wr_en;
    logic        w_int_clr;

    spi_serf_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .ss_fall   (w_ss_fall),
        .ss_rise   (w_ss_rise),
        .sclk_rise (w_sclk_rise),
        .sclk_fall (w_sclk_fall),
        .mosi_s    (w_mosi_s)
    );

    generate
        if (ODR_CYC < 16'd2) begin : g_odr_check
            $error("ODR_CYC must be at least 2");
        end
    endgenerate

`ifdef INERT_SERF_PERIODIC_EN
    logic [15:0] r_odr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_odr_cnt <= 16'd0;
        end else if (r_odr_cnt == ODR_CYC - 16'd1) begin
            r_odr_cnt <= 16'd0;
        end else begin
            r_odr_cnt <= r_odr_cnt + 16'd1;
        end
    end

    assign w_upd = (r_odr_cnt == ODR_CYC - 16'd1);
`else
    assign w_upd = upd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_nxt = SHIFT;
            SHIFT:   if (w_ss_rise) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The 8th rise completes the command byte, so the read address is taken from
    // the post-shift value and the byte lands in tx before the 9th SCLK fall.
    assign w_rx_nxt  = {r_rx[14:0], w_mosi_s};
    assign w_load_rd = (r_state == SHIFT) && w_sclk_rise &&
                       (r_bit_cnt == BIT_CNT_BYTE) && w_rx_nxt[7];

    always_comb begin
        w_rd_byte = 8'h00;
        case (w_rx_nxt[6:0])
            INT_CTRL_ADDR: w_rd_byte = r_int_ctrl;
            CFG_10_ADDR:   w_rd_byte = r_cfg10;
            CFG_11_ADDR:   w_rd_byte = r_cfg11;
            CFG_14_ADDR:   w_rd_byte = r_cfg14;
            ROLL_L_ADDR:   w_rd_byte = r_roll[7:0];
            ROLL_H_ADDR:   w_rd_byte = r_roll[15:8];
            YAW_L_ADDR:    w_rd_byte = r_yaw[7:0];
            YAW_H_ADDR:    w_rd_byte = r_yaw[15:8];
            AY_L_ADDR:     w_rd_byte = r_ay[7:0];
            AY_H_ADDR:     w_rd_byte = r_ay[15:8];
            AZ_L_ADDR:     w_rd_byte = r_az[7:0];
            AZ_H_ADDR:     w_rd_byte = r_az[15:8];
            default:       w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= 5'd0;
            r_rx      <= 16'h0000;
            r_tx      <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_bit_cnt <= 5'd0;
                        r_tx      <= 16'h0000;
                    end
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx <= w_rx_nxt;
                        if (r_bit_cnt != BIT_CNT_SAT) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    if (w_load_rd) begin
                        r_tx[15:8] <= w_rd_byte;
                    end else if (w_sclk_fall) begin
                        r_tx <= {r_tx[14:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    // Frames that are short or over-long are discarded at commit.
    assign w_commit_ok = (r_state == COMMIT) && (r_bit_cnt == BIT_CNT_FRAME);
    assign w_wr_en     = w_commit_ok && !r_rx[15];
    assign w_int_clr   = w_commit_ok &&  r_rx[15] && (r_rx[14:8] == AZ_H_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ctrl <= 8'h00;
            r_cfg10    <= 8'h00;
            r_cfg11    <= 8'h00;
            r_cfg14    <= 8'h00;
        end else if (w_wr_en) begin
            case (r_rx[14:8])
                INT_CTRL_ADDR: r_int_ctrl <= r_rx[7:0];
                CFG_10_ADDR:   r_cfg10    <= r_rx[7:0];
                CFG_11_ADDR:   r_cfg11    <= r_rx[7:0];
                CFG_14_ADDR:   r_cfg14    <= r_rx[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_roll <= 16'h0000;
            r_yaw  <= 16'h0000;
            r_ay   <= 16'h0000;
            r_az   <= 16'h0000;
        end else if (w_upd) begin
            r_roll <= roll_rt;
            r_yaw  <= yaw_rt;
            r_ay   <= AY;
            r_az   <= AZ;
        end
    end

    // A fresh sample must not be lost to a concurrent AZ_H read, so set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int <= 1'b0;
        end else if (w_upd && r_int_ctrl[INT_EN_BIT]) begin
            r_int <= 1'b1;
        end else if (w_int_clr) begin
            r_int <= 1'b0;
        end
    end

    assign MISO = ~SS_n & r_tx[15];
    assign INT  = r_int;

endmodule

`default_nettype wire
